// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - R-type funct codes for the HI/LO instructions. The ALU control decode
//     reuses them.
//   - FSM state encoding: IDLE -> RUN -> FIX.
//   - is_muldiv(): true for the four funct codes that start an iterative op.
package mdu_seq_pkg;

    typedef logic [5:0] funct_t;

    localparam funct_t F_MFHI  = 6'b010000;
    localparam funct_t F_MTHI  = 6'b010001;
    localparam funct_t F_MFLO  = 6'b010010;
    localparam funct_t F_MTLO  = 6'b010011;
    localparam funct_t F_MULT  = 6'b011000;
    localparam funct_t F_MULTU = 6'b011001;
    localparam funct_t F_DIV   = 6'b011010;
    localparam funct_t F_DIVU  = 6'b011011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic is_muldiv(input funct_t f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Core <-> multiply/divide unit connection.
//   master (core side) drives: start, f_bits, rs_val, rt_val
//   slave  (mdu side)  drives: busy, done, dz, hi, lo, mf_data
interface mdu_seq_if
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    funct_t           f_bits;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output start, f_bits, rs_val, rt_val,
        input  busy, done, dz, hi, lo, mf_data
    );

    modport slave (
        input  start, f_bits, rs_val, rt_val,
        output busy, done, dz, hi, lo, mf_data
    );
endinterface

// File: rtl/mdu_seq_step.sv
// Single iteration of the multiply/divide datapath. Purely combinational.
//   is_div_i : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_i    : 2*WIDTH working register
//              mul: {partial product, remaining multiplier bits}
//              div: {partial remainder, remaining dividend bits / quotient bits}
//   opd_i    : multiplicand (mul) or divisor (div), both unsigned magnitudes
//   acc_o    : working register after one step
module mdu_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opd_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        // Keep the carry so that the right shift brings it back into the MSB.
        sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opd_i};
        // The partial remainder shifted left with the next dividend bit fits
        // in WIDTH+1 bits. diff[WIDTH] is therefore a clean borrow.
        diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opd_i};
        if (is_div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {sum, acc_i[WIDTH-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
            end
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// The unit performs one radix-2 step per clock. From start to done takes
// WIDTH+1 edges.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset. It aborts any operation in flight.
//   bus   : slave side of mdu_seq_if
//           start/f_bits/rs_val/rt_val : issue
//           busy/done/dz               : status
//           hi/lo/mf_data              : results
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mdu_seq_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;     // negate product / quotient
    logic               rneg_q, rneg_d;   // negate remainder (dividend sign)
    logic               dzin_q, dzin_d;   // divisor was zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic               sgn_op;
    logic               div_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Two's-complement magnitude. |MIN| wraps to MIN, which reads correctly
    // as the unsigned value 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic signed_op);
        return (signed_op && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    mdu_seq_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dzin_d   = dzin_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        sgn_op   = (bus.f_bits == F_MULT) || (bus.f_bits == F_DIV);
        div_op   = (bus.f_bits == F_DIV) || (bus.f_bits == F_DIVU);
        a_mag    = mag(bus.rs_val, sgn_op);
        b_mag    = mag(bus.rt_val, sgn_op);
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_muldiv(bus.f_bits)) begin
                        is_div_d = div_op;
                        neg_d    = sgn_op && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                        rneg_d   = sgn_op && div_op && bus.rs_val[WIDTH-1];
                        dzin_d   = div_op && (bus.rt_val == '0);
                        // mul: multiplier sits in the low half and shifts out LSB first.
                        // div: dividend sits in the low half and shifts into the remainder.
                        acc_d    = div_op ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                        opd_d    = div_op ? b_mag : a_mag;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = ST_RUN;
                    end else if (bus.f_bits == F_MTHI) begin
                        hi_d = bus.rs_val;
                    end else if (bus.f_bits == F_MTLO) begin
                        lo_d = bus.rs_val;
                    end
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    // A zero divisor leaves the dividend magnitude in the high half
                    // and all ones in the quotient. Restoring the dividend sign then
                    // gives the dividend exactly as it was given.
                    hi_d = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = dzin_q ? {WIDTH{1'b1}} :
                           (neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                dz_d    = dzin_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dzin_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dzin_q   <= dzin_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.dz      = dz_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.mf_data = (bus.f_bits == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
    } mres_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(32)) bus ();
    mdu_seq_if #(.WIDTH(8))  bus8 ();

    mdu_seq #(.WIDTH(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mdu_seq #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        v = v & m;
        if (v[w-1]) return longint'(v | ~m);
        return longint'(v);
    endfunction

    // Architectural result of one HI/LO operation, computed with plain integer arithmetic.
    function automatic mres_t model(input int w, input logic [5:0] f, input logic [63:0] a_in,
                                    input logic [63:0] b_in);
        mres_t r;
        logic [63:0] m, a, b, up;
        longint sa, sb, p;
        m = (64'd1 << w) - 64'd1;
        a = a_in & m;
        b = b_in & m;
        sa = sx(a, w);
        sb = sx(b, w);
        r = '0;
        case (f)
            F_MULT: begin
                p = sa * sb;
                r.hi = (64'(p) >> w) & m;
                r.lo = 64'(p) & m;
            end
            F_MULTU: begin
                up = a * b;
                r.hi = (up >> w) & m;
                r.lo = up & m;
            end
            F_DIV: begin
                if (b == 0) begin
                    r.hi = a; r.lo = m; r.dz = 1'b1;
                end else begin
                    r.lo = 64'(sa / sb) & m;
                    r.hi = 64'(sa % sb) & m;
                end
            end
            F_DIVU: begin
                if (b == 0) begin
                    r.hi = a; r.lo = m; r.dz = 1'b1;
                end else begin
                    r.lo = (a / b) & m;
                    r.hi = (a % b) & m;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Transaction-level reference for the 32-bit unit: accepted op, remaining cycles, HI/LO.
    mres_t       pend;
    int          m_left;
    logic [31:0] m_hi, m_lo;
    logic        m_done, m_dz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (bus.start === 1'b1) begin
                    if (bus.f_bits inside {F_MULT, F_MULTU, F_DIV, F_DIVU}) begin
                        pend   <= model(W, bus.f_bits, {32'd0, bus.rs_val}, {32'd0, bus.rt_val});
                        m_left <= W + 1;
                    end else if (bus.f_bits == F_MTHI) begin
                        m_hi <= bus.rs_val;
                    end else if (bus.f_bits == F_MTLO) begin
                        m_lo <= bus.rs_val;
                    end
                end
            end else begin
                if (m_left == 1) begin
                    m_hi   <= pend.hi[31:0];
                    m_lo   <= pend.lo[31:0];
                    m_dz   <= pend.dz;
                    m_done <= 1'b1;
                end
                m_left <= m_left - 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {63'd0, bus.busy}, {63'd0, (m_left != 0)});
            check("done", {63'd0, bus.done}, {63'd0, m_done});
            check("hi", {32'd0, bus.hi}, {32'd0, m_hi});
            check("lo", {32'd0, bus.lo}, {32'd0, m_lo});
            check("mf_data", {32'd0, bus.mf_data},
                  {32'd0, (bus.f_bits == F_MFHI) ? m_hi : m_lo});
            if (m_done) check("dz", {63'd0, bus.dz}, {63'd0, m_dz});
        end
    end

    // Called at #1 after a rising edge. Operands are scrambled after the
    // issue edge, so a late sample would show up in the result.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.f_bits = f;
        bus.rs_val = a;
        bus.rt_val = b;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.f_bits = F_MFLO;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
    endtask

    task automatic wait_done(input string name, output int edges);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        if (bus.done !== 1'b1) check({name, "_timeout"}, {63'd0, bus.done}, 64'd1);
    endtask

    task automatic run_lit(input string name, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edz);
        mres_t r;
        int e;
        r = model(W, f, {32'd0, a}, {32'd0, b});
        check({name, "_model_hi"}, r.hi, {32'd0, ehi});
        check({name, "_model_lo"}, r.lo, {32'd0, elo});
        issue(f, a, b);
        wait_done(name, e);
        check({name, "_latency"}, 64'(e), 64'd33);
        check({name, "_hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        check({name, "_lo"}, {32'd0, bus.lo}, {32'd0, elo});
        check({name, "_dz"}, {63'd0, bus.dz}, {63'd0, edz});
    endtask

    task automatic run8(input string name, input logic [5:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo);
        mres_t r;
        int e;
        r = model(8, f, {56'd0, a}, {56'd0, b});
        check({name, "_model_hi"}, r.hi, {56'd0, ehi});
        check({name, "_model_lo"}, r.lo, {56'd0, elo});
        bus8.start = 1'b1; bus8.f_bits = f; bus8.rs_val = a; bus8.rt_val = b;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.f_bits = F_MFLO;
        e = 0;
        while (bus8.done !== 1'b1 && e < 50) begin
            @(posedge clk); #1;
            e++;
        end
        check({name, "_latency"}, 64'(e), 64'd9);
        check({name, "_hi"}, {56'd0, bus8.hi}, {56'd0, ehi});
        check({name, "_lo"}, {56'd0, bus8.lo}, {56'd0, elo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [4];
        int e;
        ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

        bus.start = 1'b0; bus.f_bits = F_MFLO; bus.rs_val = '0; bus.rt_val = '0;
        bus8.start = 1'b0; bus8.f_bits = F_MFLO; bus8.rs_val = '0; bus8.rt_val = '0;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_dz", {63'd0, bus.dz}, 64'd0);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_lit("mult",    F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_lit("multu",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_lit("div",     F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_lit("divmin",  F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_lit("divu0",   F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1);
        run_lit("div0neg", F_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
        run_lit("divnegb", F_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0);
        run_lit("multmin", F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        run_lit("divu",    F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0);

        for (int i = 0; i < 8; i++) begin
            issue(ops[i % 4], $urandom, (i == 6) ? 32'd0 : $urandom);
            wait_done("rand", e);
            check("rand_latency", 64'(e), 64'd33);
        end

        // Moves to HI/LO followed by reads.
        issue(F_MTHI, 32'h1234ABCD, 32'h0);
        bus.f_bits = F_MFHI; #1;
        check("mthi_mf", {32'd0, bus.mf_data}, 64'h1234ABCD);
        check("mthi_nodone", {63'd0, bus.done}, 64'd0);
        @(posedge clk); #1;
        issue(F_MTLO, 32'hCAFEF00D, 32'h0);
        #1 check("mtlo_mf", {32'd0, bus.mf_data}, 64'hCAFEF00D);

        // Reads during busy return the pre-operation HI.
        issue(F_MULTU, 32'd3, 32'd4);
        bus.f_bits = F_MFHI;
        repeat (5) @(posedge clk);
        #1 check("busy_mf", {32'd0, bus.mf_data}, 64'h1234ABCD);
        wait_done("mfbusy", e);
        check("mfbusy_lo", {32'd0, bus.lo}, 64'd12);

        // Start while running is ignored.
        issue(F_DIVU, 32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.f_bits = F_MULT; bus.rs_val = 32'd77; bus.rt_val = 32'd99;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.f_bits = F_MFLO;
        wait_done("midrun", e);
        check("midrun_lo", {32'd0, bus.lo}, 64'h64);
        check("midrun_hi", {32'd0, bus.hi}, 64'h0);
        @(posedge clk); #1;
        check("midrun_idle", {63'd0, bus.busy}, 64'd0);

        // Reset in the middle of an operation.
        issue(F_MULTU, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_hi", {32'd0, bus.hi}, 64'd0);
        check("abort_lo", {32'd0, bus.lo}, 64'd0);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_lit("after_rst", F_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

        // 8-bit instance.
        run8("w8_divu", F_DIVU, 8'hC8, 8'h07, 8'h04, 8'h1C);
        run8("w8_mult", F_MULT, 8'hFD, 8'h05, 8'hFF, 8'hF1);
        run8("w8_div",  F_DIV,  8'h80, 8'hFF, 8'h00, 8'h80);

        repeat (3) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
